// File: rtl/serial_full_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first, with a single
// full-subtractor cell and a registered borrow. Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_full_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] work_q, work_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_sgn_q, a_sgn_d;
  logic             b_sgn_q, b_sgn_d;
  logic             ovf_q, ovf_d;
`endif

  logic cell_x, cell_y, cell_z;
  logic cell_d, cell_b;
  logic last_bit;

  // The single full-subtractor cell, fed from the LSBs of the operand shifters.
  assign cell_x   = a_sh_q[0];
  assign cell_y   = b_sh_q[0];
  assign cell_z   = borrow_q;
  assign cell_d   = cell_x ^ cell_y ^ cell_z;
  assign cell_b   = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & cell_z);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    work_d   = work_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_sgn_d  = a_sgn_q;
    b_sgn_d  = b_sgn_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // work holds the WIDTH-1 most recent difference bits, newest at the top.
        work_d   = (WIDTH-1)'({cell_d, work_q} >> 1);
        borrow_d = cell_b;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = ST_DONE;
          diff_d  = {cell_d, work_q};
          bout_d  = cell_b;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_sgn_q != b_sgn_q) && (cell_d != a_sgn_q);
`endif
        end
      end
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          work_d   = '0;
          cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_sgn_d  = a[WIDTH-1];
          b_sgn_d  = b[WIDTH-1];
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      work_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_sgn_q  <= 1'b0;
      b_sgn_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      work_q   <= work_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_sgn_q  <= a_sgn_d;
      b_sgn_q  <= b_sgn_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_full_sub.sv
// Self-checking bench for serial_full_sub: WIDTH=8 instance for directed/back-to-back/reset
// scenarios and a WIDTH=2 instance for the exhaustive check; scoreboard queues hold expectations.
module tb_serial_full_sub;

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  typedef struct packed {
    logic [1:0] diff;
    logic       bout;
    logic       ovf;
  } exp2_t;

  logic       clk;
  logic       rst;
  logic       start, start2;
  logic [7:0] a, b;
  logic [1:0] a2, b2;
  logic       bin, bin2;
  logic       busy, done, bout;
  logic       busy2, done2, bout2;
  logic [7:0] diff;
  logic [1:0] diff2;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf, ovf2;
`endif

  int    checks = 0;
  int    errors = 0;
  exp_t  sb[$];
  exp2_t sb2[$];

  serial_full_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_full_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    exp_t e;
    e.diff = 8'(int'(av) - int'(bv) - int'(cv));
    e.bout = (int'(av) < int'(bv) + int'(cv));
    e.ovf  = (av[7] != bv[7]) && (e.diff[7] != av[7]);
    return e;
  endfunction

  // Drive one operation into the WIDTH=8 instance; returns #1 after the accepting edge.
  task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    a = va; b = vb; bin = vc; start = 1'b1;
    sb.push_back(model8(va, vb, vc));
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_busy: busy=%b want 1", busy);
    end
  endtask

  // Wait (bounded) for done, check latency, busy profile, result and one-cycle pulse.
  task automatic collect(input string tag);
    int   n;
    bit   busy_ok;
    exp_t e;
    n = 0; busy_ok = 1'b1;
    while (done !== 1'b1 && n < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done !== 1'b1 || n != 8) begin
      errors++;
      $display("FAIL %s latency: done=%b after %0d cycles, want done=1 after 8", tag, done, n);
    end
    checks++;
    if (!busy_ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: busy_ok=%b busy_at_done=%b want 1/0", tag, busy_ok, busy);
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: queue empty, want one entry", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (diff !== e.diff || bout !== e.bout) begin
      errors++;
      $display("FAIL %s result: diff=%0d bout=%b want diff=%0d bout=%b", tag, diff, bout, e.diff, e.bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s ovf: ovf=%b want %b", tag, ovf, e.ovf);
    end
`endif
    $display("txn %s: diff=%0d bout=%b (expected %0d/%b) latency=%0d", tag, diff, bout, e.diff, e.bout, n);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || diff !== e.diff || bout !== e.bout) begin
      errors++;
      $display("FAIL %s hold: done=%b diff=%0d bout=%b want done=0 diff=%0d bout=%b",
               tag, done, diff, bout, e.diff, e.bout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd0 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b diff=%0d bout=%b want all 0", busy, done, diff, bout);
    end
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || diff2 !== 2'd0 || bout2 !== 1'b0) begin
      errors++;
      $display("FAIL reset2: busy=%b done=%b diff=%0d bout=%b want all 0", busy2, done2, diff2, bout2);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0 || ovf2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: ovf=%b ovf2=%b want 0", ovf, ovf2);
    end
`endif
    rst = 1'b0;
    $display("txn reset: outputs cleared");
  endtask

  task automatic test_directed();
    launch(8'd200, 8'd55, 1'b0);  collect("200-55-0");
    checks++;
    if (diff !== 8'd145) begin
      errors++;
      $display("FAIL spec_200_55: diff=%0d want 145", diff);
    end
    launch(8'd5, 8'd3, 1'b1);     collect("5-3-1");
    launch(8'd0, 8'd1, 1'b0);     collect("0-1-0");
    checks++;
    if (diff !== 8'd255 || bout !== 1'b1) begin
      errors++;
      $display("FAIL spec_0_1: diff=%0d bout=%b want 255/1", diff, bout);
    end
    launch(8'd255, 8'd255, 1'b1); collect("255-255-1");
    launch(8'd0, 8'd0, 1'b0);     collect("0-0-0");
    launch(8'd255, 8'd0, 1'b1);   collect("255-0-1");
    launch(8'd0, 8'd255, 1'b1);   collect("0-255-1");
    for (int i = 0; i < 4; i++) begin
      launch(8'($urandom), 8'($urandom), 1'($urandom));
      collect("random");
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    launch(8'h80, 8'h01, 1'b0); collect("ovf_80_01");
    checks++;
    if (diff !== 8'h7F || ovf !== 1'b1) begin
      errors++;
      $display("FAIL spec_ovf_80_01: diff=%h ovf=%b want 7f/1", diff, ovf);
    end
    launch(8'h10, 8'h01, 1'b0); collect("ovf_10_01");
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL spec_ovf_10_01: ovf=%b want 0", ovf);
    end
    launch(8'h7F, 8'hFF, 1'b1); collect("ovf_7f_ff_1");
  endtask
`endif

  task automatic test_exhaustive_w2();
    int    n;
    exp2_t e;
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a2 = 2'(ia); b2 = 2'(ib); bin2 = 1'(ic); start2 = 1'b1;
          e.diff = 2'(ia - ib - ic);
          e.bout = (ia < ib + ic);
          e.ovf  = (a2[1] != b2[1]) && (e.diff[1] != a2[1]);
          sb2.push_back(e);
          @(posedge clk); #1;
          start2 = 1'b0;
          n = 0;
          while (done2 !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
          end
          e = sb2.pop_front();
          checks++;
          if (done2 !== 1'b1 || n != 2) begin
            errors++;
            $display("FAIL w2_latency a=%0d b=%0d bin=%0d: %0d cycles want 2", ia, ib, ic, n);
          end
          checks++;
          if (diff2 !== e.diff || bout2 !== e.bout) begin
            errors++;
            $display("FAIL w2_result a=%0d b=%0d bin=%0d: diff=%0d bout=%b want %0d/%b",
                     ia, ib, ic, diff2, bout2, e.diff, e.bout);
          end
`ifdef SERIAL_SUB_OVF_EN
          checks++;
          if (ovf2 !== e.ovf) begin
            errors++;
            $display("FAIL w2_ovf a=%0d b=%0d bin=%0d: ovf=%b want %b", ia, ib, ic, ovf2, e.ovf);
          end
`endif
          $display("txn w2 %0d-%0d-%0d: diff=%0d bout=%b", ia, ib, ic, diff2, bout2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    exp_t e;
    a = 8'd100; b = 8'd30; bin = 1'b0; start = 1'b1;
    sb.push_back(model8(8'd100, 8'd30, 1'b0));
    @(posedge clk); #1;
    n = 0;
    // start stays high and operands churn while busy: none of it may be taken.
    while (done !== 1'b1 && n < 20) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || n != 8 || diff !== e.diff || bout !== e.bout) begin
      errors++;
      $display("FAIL b2b_first: done=%b n=%0d diff=%0d bout=%b want 1/8/%0d/%b", done, n, diff, bout, e.diff, e.bout);
    end
    $display("txn b2b_first: diff=%0d bout=%b latency=%0d", diff, bout, n);
    a = 8'd17; b = 8'd90; bin = 1'b1;
    sb.push_back(model8(8'd17, 8'd90, 1'b1));
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || n != 9 || diff !== e.diff || bout !== e.bout) begin
      errors++;
      $display("FAIL b2b_second: done=%b n=%0d diff=%0d bout=%b want 1/9/%0d/%b", done, n, diff, bout, e.diff, e.bout);
    end
    $display("txn b2b_second: diff=%0d bout=%b cycles_after_first_done=%0d", diff, bout, n);
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    launch(8'h33, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd0 || bout !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b diff=%0d bout=%b want all 0", busy, done, diff, bout);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrun_no_done: done pulse seen=1 want 0");
    end
    $display("txn midrun_reset: aborted");
    launch(8'd77, 8'd78, 1'b0); collect("after_reset");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    a = '0; b = '0; bin = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
    test_reset();
    test_directed();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_exhaustive_w2();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
